exec_issue_ctrl: RTL

Issue controller between decode and the execute stage. Accepts one RV32I instruction per cycle from decode over a valid/ready handshake and drives the execute stage's instruction register. It holds a scoreboard of destination registers still in flight through execute/memory/writeback and stalls any instruction whose source registers are pending (pure interlock, no forwarding). Also handles execute-stage flush and counts hazard stall cycles.

---
 rtl/exec_issue_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/exec_issue_ctrl.sv
// Issue controller between decode and execute: RAW interlock against a
// shift-register scoreboard of in-flight destination registers, flush, stall counting.
module exec_issue_ctrl #(
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid_i,
    input  logic [31:0]      dec_instr_i,
    output logic             dec_ready_o,
    input  logic             flush_i,
    output logic             ex_valid_o,
    output logic [31:0]      ex_instr_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [PIPE_DEPTH-1:0]      sb_vld_q;
    logic [PIPE_DEPTH-1:0][4:0] sb_rd_q;
    logic                       ex_valid_q;
    logic [31:0]                ex_instr_q;
    logic [CNT_W-1:0]           stall_cnt_q;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       writes_rd, reads_rs1, reads_rs2;
    logic       hazard, issue;

    assign opcode = dec_instr_i[6:0];
    assign rd     = dec_instr_i[11:7];
    assign rs1    = dec_instr_i[19:15];
    assign rs2    = dec_instr_i[24:20];

    always_comb begin
        writes_rd = 1'b0;
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM: begin writes_rd = 1'b1; reads_rs1 = 1'b1; end
            OP_OP:     begin writes_rd = 1'b1; reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
            OP_BRANCH, OP_STORE: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
            default: ;
        endcase
    end

    // x0 is never tracked, so it is also excluded from the source compare
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (sb_vld_q[k] &&
                ((reads_rs1 && rs1 != 5'd0 && rs1 == sb_rd_q[k]) ||
                 (reads_rs2 && rs2 != 5'd0 && rs2 == sb_rd_q[k])))
                hazard = 1'b1;
        end
        hazard = hazard && dec_valid_i;
    end

    assign dec_ready_o = !hazard && !flush_i;
    assign issue       = dec_valid_i && dec_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_vld_q    <= '0;
            sb_rd_q     <= '0;
            ex_valid_q  <= 1'b0;
            ex_instr_q  <= 32'h0;
            stall_cnt_q <= '0;
        end else begin
            // a flushed slot 0 shifts on as invalid so its rd never blocks
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                sb_vld_q[k] <= (k == 1) ? (sb_vld_q[0] && !flush_i) : sb_vld_q[k-1];
                sb_rd_q[k]  <= sb_rd_q[k-1];
            end
            sb_vld_q[0] <= issue && writes_rd && rd != 5'd0;
            sb_rd_q[0]  <= (issue && writes_rd) ? rd : 5'd0;
            ex_valid_q  <= issue;
            ex_instr_q  <= issue ? dec_instr_i : 32'h0;
            if (hazard && !flush_i && stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ex_valid_o  = ex_valid_q;
    assign ex_instr_o  = ex_instr_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
